// File: rtl/adc_pkg.sv
// Shared constants, config-field layout and state type for the LTC2308-style ADC responder.
package adc_pkg;

  localparam int unsigned ADC_BITS = 12;
  localparam int unsigned CFG_BITS = 6;

  // Bit positions inside the 6-bit config word {S/D,O/S,S1,S0,UNI,SLP}
  localparam int unsigned CFG_SD  = 5;
  localparam int unsigned CFG_OS  = 4;
  localparam int unsigned CFG_S1  = 3;
  localparam int unsigned CFG_S0  = 2;
  localparam int unsigned CFG_UNI = 1;
  localparam int unsigned CFG_SLP = 0;

  localparam logic [5:0] CFG_RESET = 6'b100010;

  // Full DIN frames selecting each single-ended unipolar channel
  localparam logic [11:0] CH0 = 12'b100010_000000;
  localparam logic [11:0] CH1 = 12'b110010_000000;
  localparam logic [11:0] CH2 = 12'b100110_000000;
  localparam logic [11:0] CH3 = 12'b110110_000000;
  localparam logic [11:0] CH4 = 12'b101010_000000;
  localparam logic [11:0] CH5 = 12'b111010_000000;
  localparam logic [11:0] CH6 = 12'b101110_000000;
  localparam logic [11:0] CH7 = 12'b111110_000000;

  typedef enum logic [1:0] {StIdle, StConvert, StShift} adc_resp_state_t;

  function automatic logic [2:0] cfg_to_ch(input logic [5:0] cfg);
    return {cfg[CFG_S1], cfg[CFG_S0], cfg[CFG_OS]};
  endfunction

  function automatic logic cfg_is_bad(input logic [5:0] cfg);
    return ~cfg[CFG_SD] | ~cfg[CFG_UNI];
  endfunction

endpackage

// File: rtl/sync_edge.sv
// Multi-flop synchronizer followed by a registered edge detector.
module sync_edge #(
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic d_i,
  output logic level_o,
  output logic rise_o,
  output logic fall_o
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   prev_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sync_q <= '0;
      prev_q <= 1'b0;
    end else begin
      sync_q[0] <= d_i;
      for (int i = 1; i < SYNC_STAGES; i++) begin
        sync_q[i] <= sync_q[i-1];
      end
      prev_q <= sync_q[SYNC_STAGES-1];
    end
  end

  assign level_o = sync_q[SYNC_STAGES-1];
  assign rise_o  = level_o & ~prev_q;
  assign fall_o  = ~level_o & prev_q;

endmodule

// File: rtl/adc_responder.sv
// Serial ADC responder: decodes CONVST/SCLK/DIN, runs a timed conversion, shifts a sample out.
module adc_responder
  import adc_pkg::*;
#(
  parameter int unsigned CONV_CYCLES = 80,
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned ADC_BITS    = adc_pkg::ADC_BITS
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  input  logic                conv_start_i,
  input  logic                sclk_i,
  input  logic                din_i,
  output logic                dout_o,
  output logic                sample_req_o,
  output logic [2:0]          sample_ch_o,
  input  logic [ADC_BITS-1:0] sample_data_i,
  output logic                busy_o,
  output logic                frame_done_o,
  output logic [5:0]          cfg_word_o,
  output logic                cfg_err_o
);

  localparam int unsigned CntW = $clog2(CONV_CYCLES + 1);
  localparam int unsigned BitW = $clog2(ADC_BITS + 1);

  logic cs_rise, cs_level_unused, cs_fall_unused;
  logic sclk_rise, sclk_fall, sclk_level_unused;
  logic din_lvl, din_rise_unused, din_fall_unused;

  sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sync_cs (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .d_i    (conv_start_i),
    .level_o(cs_level_unused),
    .rise_o (cs_rise),
    .fall_o (cs_fall_unused)
  );

  sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sync_sclk (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .d_i    (sclk_i),
    .level_o(sclk_level_unused),
    .rise_o (sclk_rise),
    .fall_o (sclk_fall)
  );

  sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sync_din (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .d_i    (din_i),
    .level_o(din_lvl),
    .rise_o (din_rise_unused),
    .fall_o (din_fall_unused)
  );

  adc_resp_state_t     state_q;
  logic [CntW-1:0]     conv_cnt_q;
  logic [BitW-1:0]     bit_cnt_q;
  logic [ADC_BITS-1:0] cap_q, sample_q;
  logic [5:0]          cfg_q, cfg_new;
  logic [2:0]          ch_q;
  logic                cfg_err_q, sample_req_q, busy_q, frame_done_q, dout_q;

  // The first six DIN bits of the last frame sit at cap_q[n-1 -: 6] after n rises.
  always_comb begin
    cfg_new = cfg_q;
    if (bit_cnt_q >= BitW'(CFG_BITS)) begin
      cfg_new = CFG_BITS'(cap_q >> (bit_cnt_q - BitW'(CFG_BITS)));
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q      <= StIdle;
      conv_cnt_q   <= '0;
      bit_cnt_q    <= '0;
      cap_q        <= '0;
      sample_q     <= '0;
      cfg_q        <= CFG_RESET;
      ch_q         <= '0;
      cfg_err_q    <= 1'b0;
      sample_req_q <= 1'b0;
      busy_q       <= 1'b0;
      frame_done_q <= 1'b0;
      dout_q       <= 1'b0;
    end else begin
      sample_req_q <= 1'b0;
      frame_done_q <= 1'b0;
      if (sample_req_q) sample_q <= sample_data_i;
      unique case (state_q)
        StIdle, StShift: begin
          // CONVST wins over any SCLK edge seen in the same cycle
          if (cs_rise) begin
            cfg_q        <= cfg_new;
            cfg_err_q    <= cfg_is_bad(cfg_new);
            ch_q         <= cfg_to_ch(cfg_new);
            sample_req_q <= 1'b1;
            busy_q       <= 1'b1;
            dout_q       <= 1'b0;
            conv_cnt_q   <= '0;
            state_q      <= StConvert;
          end else if (state_q == StShift) begin
            if (sclk_rise && bit_cnt_q < BitW'(ADC_BITS)) begin
              cap_q     <= {cap_q[ADC_BITS-2:0], din_lvl};
              bit_cnt_q <= bit_cnt_q + 1'b1;
              if (bit_cnt_q == BitW'(ADC_BITS - 1)) frame_done_q <= 1'b1;
            end else if (sclk_fall) begin
              if (bit_cnt_q == BitW'(ADC_BITS)) begin
                dout_q <= 1'b0;
              end else if (bit_cnt_q != '0) begin
                dout_q <= sample_q[BitW'(ADC_BITS - 1) - bit_cnt_q];
              end
            end
          end
        end
        StConvert: begin
          if (conv_cnt_q == CntW'(CONV_CYCLES - 1)) begin
            dout_q    <= sample_q[ADC_BITS-1];
            busy_q    <= 1'b0;
            bit_cnt_q <= '0;
            cap_q     <= '0;
            state_q   <= StShift;
          end else begin
            conv_cnt_q <= conv_cnt_q + 1'b1;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign dout_o       = dout_q;
  assign sample_req_o = sample_req_q;
  assign sample_ch_o  = ch_q;
  assign busy_o       = busy_q;
  assign frame_done_o = frame_done_q;
  assign cfg_word_o   = cfg_q;
  assign cfg_err_o    = cfg_err_q;

endmodule

// File: tb/tb_adc_responder.sv
// Scoreboard bench for adc_responder: expected conversion requests queued, monitor compares.
module tb_adc_responder;
  import adc_pkg::*;

  typedef struct packed {
    logic [2:0] ch;
    logic [5:0] cfg;
    logic       err;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        conv_start = 1'b0, sclk = 1'b0, din = 1'b0;
  logic        dout, sample_req, busy, frame_done, cfg_err;
  logic [2:0]  sample_ch;
  logic [5:0]  cfg_word;
  logic [11:0] sample_data = '0;

  int   checks = 0;
  int   errors = 0;
  int   fd_cnt = 0;
  exp_t exp_q[$];

  always #5 clk = ~clk;

  adc_responder #(.CONV_CYCLES(80), .SYNC_STAGES(2), .ADC_BITS(12)) dut (
    .clk_i        (clk),
    .rst_ni       (rst_n),
    .conv_start_i (conv_start),
    .sclk_i       (sclk),
    .din_i        (din),
    .dout_o       (dout),
    .sample_req_o (sample_req),
    .sample_ch_o  (sample_ch),
    .sample_data_i(sample_data),
    .busy_o       (busy),
    .frame_done_o (frame_done),
    .cfg_word_o   (cfg_word),
    .cfg_err_o    (cfg_err)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Monitor: every sample_req must match the oldest queued expectation
  always @(negedge clk) begin
    if (frame_done === 1'b1) fd_cnt++;
    if (sample_req === 1'b1) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_sample_req", {31'd0, sample_req}, 32'd0);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        chk("sample_ch", {29'd0, sample_ch}, {29'd0, e.ch});
        chk("cfg_word", {26'd0, cfg_word}, {26'd0, e.cfg});
        chk("cfg_err", {31'd0, cfg_err}, {31'd0, e.err});
      end
    end
  end

  task automatic check_reset_vals(input string tag);
    chk({tag, "_dout"}, {31'd0, dout}, 32'd0);
    chk({tag, "_sample_req"}, {31'd0, sample_req}, 32'd0);
    chk({tag, "_busy"}, {31'd0, busy}, 32'd0);
    chk({tag, "_frame_done"}, {31'd0, frame_done}, 32'd0);
    chk({tag, "_cfg_word"}, {26'd0, cfg_word}, 32'b100010);
    chk({tag, "_cfg_err"}, {31'd0, cfg_err}, 32'd0);
    chk({tag, "_sample_ch"}, {29'd0, sample_ch}, 32'd0);
  endtask

  // Raise CONVST, check latency and busy length; noise=1 adds CONVST/SCLK activity mid-conversion
  task automatic start_conv(input exp_t e, input logic [11:0] data, input bit noise);
    int n;
    exp_q.push_back(e);
    sample_data = data;
    @(negedge clk);
    conv_start = 1'b1;
    repeat (2) @(negedge clk);
    chk("req_not_early", {31'd0, sample_req}, 32'd0);
    @(negedge clk);
    chk("req_latency", {31'd0, sample_req}, 32'd1);
    n = 0;
    while (busy === 1'b1 && n < 200) begin
      if (n == 5) conv_start = 1'b0;
      if (noise) begin
        if (n == 20) conv_start = 1'b1;
        if (n == 30) conv_start = 1'b0;
        if (n == 40 || n == 52) sclk = 1'b1;
        if (n == 46 || n == 58) sclk = 1'b0;
      end
      if (n == 50) chk("dout_zero_in_convert", {31'd0, dout}, 32'd0);
      n++;
      @(negedge clk);
    end
    conv_start = 1'b0;
    chk("busy_length", n, 32'd80);
    chk("dout_msb_after_convert", {31'd0, dout}, {31'd0, data[11]});
  endtask

  // Master side: data captured just before each SCLK rise, DIN driven MSB-first
  task automatic frame(input logic [11:0] tx, input int nbits, output logic [11:0] rx);
    rx = '0;
    for (int i = 0; i < nbits; i++) begin
      din = tx[11-i];
      repeat (5) @(negedge clk);
      rx[11-i] = dout;
      sclk = 1'b1;
      repeat (5) @(negedge clk);
      sclk = 1'b0;
    end
    repeat (8) @(negedge clk);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [11:0] rx;
    int          fd0;

    repeat (3) @(negedge clk);
    #1 check_reset_vals("reset");
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);

    // First conversion with no prior frame: channel 0
    start_conv('{ch: 3'd0, cfg: 6'b100010, err: 1'b0}, 12'hA5C, 1'b0);
    fd0 = fd_cnt;
    frame(CH5, 12, rx);
    chk("rx_a5c", {20'd0, rx}, 32'hA5C);
    chk("frame_done_once", fd_cnt - fd0, 32'd1);
    chk("dout_zero_after_frame", {31'd0, dout}, 32'd0);

    // CH5 committed; shift a non-single-ended word next
    start_conv('{ch: 3'd5, cfg: 6'b111010, err: 1'b0}, 12'h3C7, 1'b0);
    frame(12'b000010_000000, 12, rx);
    chk("rx_3c7", {20'd0, rx}, 32'h3C7);

    start_conv('{ch: 3'd0, cfg: 6'b000010, err: 1'b1}, 12'h812, 1'b0);
    fd0 = fd_cnt;
    frame(CH7, 4, rx);
    chk("rx_partial", {28'd0, rx[11:8]}, 32'h8);
    chk("no_frame_done_partial", fd_cnt - fd0, 32'd0);

    // Abort after 4 bits keeps config; CONVERT ignores CONVST/SCLK noise
    start_conv('{ch: 3'd0, cfg: 6'b000010, err: 1'b1}, 12'h6B9, 1'b1);
    frame(CH2, 12, rx);
    chk("rx_6b9", {20'd0, rx}, 32'h6B9);

    start_conv('{ch: 3'd2, cfg: 6'b100110, err: 1'b0}, 12'h5A1, 1'b0);
    frame(CH6, 6, rx);
    chk("rx_partial6", {26'd0, rx[11:6]}, 32'h5A1 >> 6);

    // Reset mid-frame at bit 6
    @(negedge clk);
    rst_n = 1'b0;
    #1 check_reset_vals("midreset");
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);

    start_conv('{ch: 3'd0, cfg: 6'b100010, err: 1'b0}, 12'h1F0, 1'b0);
    frame(CH1, 12, rx);
    chk("rx_1f0", {20'd0, rx}, 32'h1F0);

    start_conv('{ch: 3'd1, cfg: 6'b110010, err: 1'b0}, 12'hFFF, 1'b0);
    frame(CH0, 12, rx);
    chk("rx_fff", {20'd0, rx}, 32'hFFF);

    repeat (10) @(negedge clk);
    chk("scoreboard_drained", exp_q.size(), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
